// File: rtl/mips_pkg.sv
// Constants shared by the register file, the destination-register mux and the hazard unit.
package mips_pkg;

    localparam int unsigned DEF_NBITS = 32;
    localparam int unsigned DEF_RBITS = 5;
    localparam int unsigned DEF_NREGS = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/reg_bank_rdport.sv
// One ID-stage read port: array select, hardwired-zero check and optional same-cycle bypass.
module reg_bank_rdport
    import mips_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned RBITS = DEF_RBITS,
    parameter int unsigned NREGS = DEF_NREGS
) (
    input  logic [NREGS-1:0][NBITS-1:0] i_mem,
    input  logic [RBITS-1:0]            i_rd_reg,
    input  logic                        i_byp_en,
    input  logic [RBITS-1:0]            i_wr_reg,
    input  logic [NBITS-1:0]            i_wr_data,
    output logic [NBITS-1:0]            o_rd_data
);

    logic w_is_zero;
    logic w_hit;

    assign w_is_zero = (i_rd_reg == RBITS'(REG_ZERO));
    assign w_hit     = i_byp_en && (i_wr_reg == i_rd_reg);

    // Zero check has priority so a discarded write to r0 can never leak through the bypass.
    always_comb begin
        o_rd_data = i_mem[i_rd_reg];
        if (w_is_zero) begin
            o_rd_data = '0;
        end else if (w_hit) begin
            o_rd_data = i_wr_data;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// MIPS general-purpose register file: 2 combinational read ports, 1 write port, 1 debug port.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data onto read ports A and B.
module reg_bank
    import mips_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned RBITS = DEF_RBITS,
    parameter int unsigned NREGS = DEF_NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [RBITS-1:0] wr_reg,
    input  logic [NBITS-1:0] wr_data,
    input  logic [RBITS-1:0] rd_reg_a,
    input  logic [RBITS-1:0] rd_reg_b,
    output logic [NBITS-1:0] rd_data_a,
    output logic [NBITS-1:0] rd_data_b,
    input  logic [RBITS-1:0] dbg_reg,
    output logic [NBITS-1:0] dbg_data
);

    logic [NREGS-1:0][NBITS-1:0] r_mem;
    logic                        w_wr_commit;
    logic                        w_byp_en;

    assign w_wr_commit = wr_en && (wr_reg != RBITS'(REG_ZERO));

    // r0 is reset and never written, so the debug port needs no zero check of its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (w_wr_commit) begin
            r_mem[wr_reg] <= wr_data;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    // Gated by rst_n so outputs stay 0 while reset is held.
    assign w_byp_en = rst_n && wr_en;
`else
    assign w_byp_en = 1'b0;
`endif

    reg_bank_rdport #(
        .NBITS (NBITS),
        .RBITS (RBITS),
        .NREGS (NREGS)
    ) u_rdport_a (
        .i_mem     (r_mem),
        .i_rd_reg  (rd_reg_a),
        .i_byp_en  (w_byp_en),
        .i_wr_reg  (wr_reg),
        .i_wr_data (wr_data),
        .o_rd_data (rd_data_a)
    );

    reg_bank_rdport #(
        .NBITS (NBITS),
        .RBITS (RBITS),
        .NREGS (NREGS)
    ) u_rdport_b (
        .i_mem     (r_mem),
        .i_rd_reg  (rd_reg_b),
        .i_byp_en  (w_byp_en),
        .i_wr_reg  (wr_reg),
        .i_wr_data (wr_data),
        .o_rd_data (rd_data_b)
    );

    assign dbg_data = r_mem[dbg_reg];

endmodule

// File: tb/tb_reg_bank.sv
// Randomized self-checking bench for reg_bank against an array-based reference model.
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  rd_reg_a;
    logic [4:0]  rd_reg_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [4:0]  dbg_reg;
    logic [31:0] dbg_data;

    logic [31:0] model [32];
    int          n_cmp;
    int          n_err;

    reg_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_reg_a  (rd_reg_a),
        .rd_reg_b  (rd_reg_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .dbg_reg   (dbg_reg),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Architectural read value: r0 is zero, reset forces zero, bypass sees the pending write.
    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (!rst_n || addr == 5'd0) return 32'h0;
        if (byp && BYPASS && wr_en && wr_reg == addr) return wr_data;
        return model[addr];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dr);
        wr_en    = we;
        wr_reg   = wr;
        wr_data  = wd;
        rd_reg_a = ra;
        rd_reg_b = rb;
        dbg_reg  = dr;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check_eq({tag, ".a"},   rd_data_a, exp_read(rd_reg_a, 1'b1));
        check_eq({tag, ".b"},   rd_data_b, exp_read(rd_reg_b, 1'b1));
        check_eq({tag, ".dbg"}, dbg_data,  exp_read(dbg_reg, 1'b0));
    endtask

    task automatic commit();
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        we = wr_en;
        wr = wr_reg;
        wd = wr_data;
        @(posedge clk);
        if (rst_n && we && wr != 5'd0) model[wr] = wd;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_model();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #12;
        check_reads("reset_init");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset: clears without a clock edge, and wins over a concurrent write.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        commit();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        check_reads("r5_written");
        check_eq("r5_value", dbg_data, 32'hDEADBEEF);
        drive(1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd5, 5'd5);
        #1;
        rst_n = 1'b0;
        clear_model();
        check_reads("reset_async");
        commit();
        check_reads("reset_held_edge");
        #2;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        check_reads("reset_released");

        // Write then read on all ports.
        commit();
        drive(1'b1, 5'd7, 32'h12345678, 5'd1, 5'd2, 5'd3);
        commit();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        check_reads("wr_rd_r7");
        check_eq("r7_value", rd_data_a, 32'h12345678);

        // r0 is hardwired zero, including the cycle of the attempted write.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        check_reads("r0_write_cycle");
        commit();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check_reads("r0_after");

        // Same-cycle write/read hazard.
        drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, 5'd0);
        commit();
        drive(1'b1, 5'd3, 32'h2, 5'd3, 5'd3, 5'd3);
        check_reads("hazard_same");
        check_eq("hazard_dbg_old", dbg_data, 32'h1);
        commit();
        drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd3, 5'd3);
        check_reads("hazard_next");

        // Write disabled.
        drive(1'b0, 5'd9, 32'hAAAA5555, 5'd9, 5'd9, 5'd9);
        commit();
        check_reads("wr_disabled");
        check_eq("r9_unchanged", dbg_data, 32'h0);

        // Link write plus fill of r1..r30, then full read-back on all ports.
        drive(1'b1, 5'd31, 32'h00400008, 5'd0, 5'd0, 5'd0);
        commit();
        for (int i = 1; i < 31; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'(i), 5'(31 - i), 5'(i));
            check_reads("fill");
            commit();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'(i), 32'hFFFFFFFF, 5'(i), 5'(31 - i), 5'(i));
            check_reads("readback");
            commit();
        end

        // Random traffic, biased so write addresses often collide with read addresses.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra;
            logic [4:0] rb;
            logic [4:0] wr;
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: wr = ra;
                1: wr = rb;
                default: wr = 5'($urandom_range(0, 31));
            endcase
            drive(1'($urandom_range(0, 1)), wr, $urandom, ra, rb, 5'($urandom_range(0, 31)));
            check_reads("random");
            commit();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
